// File: rtl/cmos_dvp_capture_pkg.sv
// Shared video definitions for the DVP capture front end. The frame geometry
// defaults must match those used by the motion-box stage.
package cmos_dvp_capture_pkg;

    localparam logic [14:0] IMG_WIDTH_DEF   = 15'd800;
    localparam logic [14:0] IMG_HEIGHT_DEF  = 15'd600;
    localparam logic [3:0]  WAIT_FRAMES_DEF = 4'd10;
    localparam logic [14:0] CNT_MAX         = 15'h7FFF;

    typedef enum logic {
        ST_SKIP = 1'b0,
        ST_PASS = 1'b1
    } frame_state_e;

    // MSB replication so that full-scale 565 maps to full-scale 888
    function automatic logic [23:0] rgb565_to_888(input logic [15:0] px);
        return {px[15:11], px[15:13], px[10:5], px[10:9], px[4:0], px[4:2]};
    endfunction

    function automatic logic [14:0] sat_inc(input logic [14:0] v);
        return (v == CNT_MAX) ? v : v + 15'd1;
    endfunction

endpackage

// File: rtl/cmos_dvp_capture_if.sv
// Sensor byte stream in, RGB888 pixel stream and frame status out.
interface cmos_dvp_capture_if;

    logic        cmos_vsync;
    logic        cmos_href;
    logic [7:0]  cmos_data;
    logic        post_frame_vsync;
    logic        post_frame_href;
    logic        post_frame_clken;
    logic [23:0] post_img_24bit;
    logic        frame_valid;
    logic        frame_err;

    modport master (
        input  cmos_vsync, cmos_href, cmos_data,
        output post_frame_vsync, post_frame_href, post_frame_clken,
        output post_img_24bit, frame_valid, frame_err
    );

    modport slave (
        output cmos_vsync, cmos_href, cmos_data,
        input  post_frame_vsync, post_frame_href, post_frame_clken,
        input  post_img_24bit, frame_valid, frame_err
    );

endinterface

// File: rtl/cmos_dvp_capture.sv
// DVP RGB565 byte stream to RGB888 pixel stream with start-up frame skip and
// per-frame geometry check, all on the sensor pixel clock.
//   state   | meaning
//   ST_SKIP | sensor settling, every post_* output held at 0
//   ST_PASS | frames forwarded, stays here until reset
module cmos_dvp_capture
    import cmos_dvp_capture_pkg::*;
#(
    parameter logic [14:0] IMG_WIDTH   = IMG_WIDTH_DEF,
    parameter logic [14:0] IMG_HEIGHT  = IMG_HEIGHT_DEF,
    parameter logic [3:0]  WAIT_FRAMES = WAIT_FRAMES_DEF
) (
    input logic                clk,
    input logic                rst_n,
    cmos_dvp_capture_if.master vid
);

    logic         r_vsync, r_href, r_vsync_d1, r_href_d1;
    logic [7:0]   r_data, r_hi;
    logic         r_phase, r_skip_line;
    logic         r_pix_vld;
    logic [15:0]  r_rgb565;
    logic [3:0]   r_frame_cnt;
    frame_state_e r_state, w_state_nxt;
    logic [14:0]  r_x_cnt, r_y_cnt;
    logic         r_frame_bad;
    logic         r_post_vsync, r_post_href, r_post_clken;
    logic [23:0]  r_post_img;
    logic         r_frame_valid, r_frame_err;

    logic         w_vs_rise, w_href_rise, w_href_fall;
    logic         w_cut, w_live, w_fall, w_line_bad, w_pass;
    logic [14:0]  w_y_eff;

    assign w_vs_rise   = r_vsync & ~r_vsync_d1;
    assign w_href_rise = r_href & ~r_href_d1;
    assign w_href_fall = ~r_href & r_href_d1;
    // a line still open at the frame boundary is closed as bad and the rest of it is ignored
    assign w_cut       = w_vs_rise & r_href;
    assign w_live      = r_href & ~r_skip_line & ~w_cut;
    assign w_fall      = w_href_fall & ~r_skip_line;
    assign w_line_bad  = w_fall & ((r_x_cnt != IMG_WIDTH) | r_phase);
    assign w_y_eff     = w_fall ? sat_inc(r_y_cnt) : r_y_cnt;
    assign w_pass      = (r_state == ST_PASS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync    <= 1'b0;
            r_href     <= 1'b0;
            r_data     <= '0;
            r_vsync_d1 <= 1'b0;
            r_href_d1  <= 1'b0;
        end else begin
            r_vsync    <= vid.cmos_vsync;
            r_href     <= vid.cmos_href;
            r_data     <= vid.cmos_data;
            r_vsync_d1 <= r_vsync;
            r_href_d1  <= r_href;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_SKIP;
            r_frame_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_vs_rise && r_frame_cnt != 4'hF)
                r_frame_cnt <= r_frame_cnt + 4'd1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_SKIP && w_vs_rise && r_frame_cnt == WAIT_FRAMES)
            w_state_nxt = ST_PASS;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase     <= 1'b0;
            r_skip_line <= 1'b0;
            r_hi        <= '0;
            r_pix_vld   <= 1'b0;
            r_rgb565    <= '0;
        end else begin
            r_phase     <= r_href ? ~r_phase : 1'b0;
            r_skip_line <= r_href ? (r_skip_line | w_cut) : 1'b0;
            r_pix_vld   <= w_live & r_phase;
            if (w_live && !r_phase)
                r_hi <= r_data;
            if (w_live && r_phase)
                r_rgb565 <= {r_hi, r_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_cnt     <= '0;
            r_y_cnt     <= '0;
            r_frame_bad <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_href_rise)
                r_x_cnt <= '0;
            else if (w_live && r_phase)
                r_x_cnt <= sat_inc(r_x_cnt);
            if (w_vs_rise) begin
                r_y_cnt     <= '0;
                r_frame_bad <= 1'b0;
                // w_pass still reflects whether the frame just closed was forwarded
                if (w_pass)
                    r_frame_err <= r_frame_bad | w_line_bad | w_cut | (w_y_eff != IMG_HEIGHT);
            end else begin
                if (w_fall)
                    r_y_cnt <= sat_inc(r_y_cnt);
                if (w_line_bad)
                    r_frame_bad <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_post_vsync  <= 1'b0;
            r_post_href   <= 1'b0;
            r_post_clken  <= 1'b0;
            r_post_img    <= '0;
            r_frame_valid <= 1'b0;
        end else begin
            r_post_vsync  <= r_vsync_d1 & w_pass;
            r_post_href   <= r_href_d1 & w_pass;
            r_post_clken  <= r_pix_vld & w_pass;
            r_frame_valid <= w_pass;
            if (r_pix_vld && w_pass)
                r_post_img <= rgb565_to_888(r_rgb565);
        end
    end

    assign vid.post_frame_vsync = r_post_vsync;
    assign vid.post_frame_href  = r_post_href;
    assign vid.post_frame_clken = r_post_clken;
    assign vid.post_img_24bit   = r_post_img;
    assign vid.frame_valid      = r_frame_valid;
    assign vid.frame_err        = r_frame_err;

endmodule
